// File: rtl/ex_div_ctrl.sv
// Sequencer for the EX-stage iterative divider (DIV/DIVU/REM/REMU) using a 32-step restoring algorithm.
// Optional build macro DIV_EARLY_OUT_EN: when |dividend| < |divisor|, finish one cycle after start.
module ex_div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] s1data,
  input  logic [31:0] s2data,
  input  logic        annul,
  output logic        stallreq,
  output logic        valid,
  output logic [31:0] result
);

  // state | meaning
  // IDLE  | waiting for start; operands are latched when a start is accepted
  // BUSY  | one shift-subtract step per cycle, steps 0..31
  // DONE  | result register holds the corrected value; valid pulses
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [31:0] dvs_q, quo_q, rem_q;
  logic [4:0]  cnt_q;
  logic        q_neg_q, r_neg_q;
  logic [31:0] result_q;

  logic        accept, is_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_sh, diff;
  logic [31:0] quo_step, rem_step, q_fix, r_fix, busy_res, zero_res;
  logic        early_hit;
  logic        load_res;
  logic [31:0] res_nxt;

  assign accept    = (state == IDLE) && start && !annul;
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & s1data[31];
  assign b_neg     = is_signed & s2data[31];
  assign a_mag     = a_neg ? (~s1data + 32'd1) : s1data;
  assign b_mag     = b_neg ? (~s2data + 32'd1) : s2data;

  // Partial remainder is widened to 33 bits so the borrow shows up in diff[32].
  assign rem_sh   = {rem_q, quo_q[31]};
  assign diff     = rem_sh - {1'b0, dvs_q};
  assign quo_step = {quo_q[30:0], ~diff[32]};
  assign rem_step = diff[32] ? rem_sh[31:0] : diff[31:0];

  assign q_fix    = q_neg_q ? (~quo_step + 32'd1) : quo_step;
  assign r_fix    = r_neg_q ? (~rem_step + 32'd1) : rem_step;
  assign busy_res = op_q[1] ? r_fix : q_fix;
  assign zero_res = op[1] ? s1data : 32'hFFFF_FFFF;

`ifdef DIV_EARLY_OUT_EN
  assign early_hit = (b_mag != 32'd0) && (a_mag < b_mag);
`else
  assign early_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    load_res  = 1'b0;
    res_nxt   = result_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (b_mag == 32'd0) begin
            state_nxt = DONE;
            load_res  = 1'b1;
            res_nxt   = zero_res;
          end else if (early_hit) begin
            // Quotient is 0 and the remainder is the untouched dividend.
            state_nxt = DONE;
            load_res  = 1'b1;
            res_nxt   = op[1] ? s1data : 32'd0;
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 5'd31) begin
          state_nxt = DONE;
          load_res  = 1'b1;
          res_nxt   = busy_res;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (annul) begin
      state_nxt = IDLE;
      load_res  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= 2'b00;
      dvs_q    <= 32'd0;
      quo_q    <= 32'd0;
      rem_q    <= 32'd0;
      cnt_q    <= 5'd0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q    <= op;
        dvs_q   <= b_mag;
        quo_q   <= a_mag;
        rem_q   <= 32'd0;
        cnt_q   <= 5'd0;
        q_neg_q <= a_neg ^ b_neg;
        r_neg_q <= a_neg;
      end else if (state == BUSY) begin
        quo_q <= quo_step;
        rem_q <= rem_step;
        cnt_q <= cnt_q + 5'd1;
      end
      if (load_res) result_q <= res_nxt;
    end
  end

  assign stallreq = accept || (state == BUSY);
  assign valid    = (state == DONE) && !annul;
  assign result   = result_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed plus randomized bench for ex_div_ctrl; expected results flow through a queue.
// Honours DIV_EARLY_OUT_EN when building latency expectations.
module tb_ex_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, annul;
  logic [1:0]  op;
  logic [31:0] s1data, s2data;
  logic        stallreq, valid;
  logic [31:0] result;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       tag;
  } exp_t;
  exp_t exp_q[$];

  ex_div_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .s1data(s1data), .s2data(s2data),
    .annul(annul), .stallreq(stallreq), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input logic [31:0] got, input logic [31:0] want, input string tag);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    case (o)
      2'b00: r = (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      2'b10: r = (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'($signed(a) % $signed(b));
      2'b01: r = a / b;
      default: r = a % b;
    endcase
    return r;
  endfunction

  function automatic int lat_of(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] am, bm;
    if (b == 32'd0) return 1;
    am = (!o[0] && a[31]) ? -a : a;
    bm = (!o[0] && b[31]) ? -b : b;
`ifdef DIV_EARLY_OUT_EN
    if (am < bm) return 1;
`else
    if (am < bm) return 33;
`endif
    return 33;
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Called at a negedge: drives a one-cycle start and returns one cycle later.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input int el, input bit push, input string tag);
    exp_t e;
    start = 1'b1; op = o; s1data = a; s2data = b;
    if (push) begin
      e.res = er; e.lat = el; e.tag = tag;
      exp_q.push_back(e);
    end
    #1 check({31'd0, stallreq}, 32'd1, {tag, "_stall_T"});
    cyc = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic collect();
    exp_t e;
    while (valid !== 1'b1 && cyc < 80) begin
      check({31'd0, stallreq}, 32'd1, "stall_busy");
      tick();
    end
    e = exp_q.pop_front();
    check({31'd0, valid}, 32'd1, {e.tag, "_valid_timeout"});
    check(32'(cyc), 32'(e.lat), {e.tag, "_latency"});
    check(result, e.res, {e.tag, "_result"});
    check({31'd0, stallreq}, 32'd0, {e.tag, "_stall_done"});
    tick();
    check({31'd0, valid}, 32'd0, {e.tag, "_valid_one_cycle"});
    check(result, e.res, {e.tag, "_result_hold"});
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input int el, input string tag);
    launch(o, a, b, er, el, 1'b1, tag);
    collect();
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    bit          saw_valid;

    rst = 1'b1; start = 1'b0; annul = 1'b0; op = 2'b00; s1data = '0; s2data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check({31'd0, valid}, 32'd0, "reset_valid");
    check(result, 32'd0, "reset_result");
    check({31'd0, stallreq}, 32'd0, "reset_stall");
    @(negedge clk);

    run(2'b01, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
    run(2'b11, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
    run(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div_m7_2");
    run(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem_m7_2");
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "div_ovf");
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "rem_ovf");
    run(2'b11, 32'd5, 32'd0, 32'd5, 1, "remu_5_0");
    run(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "divu_5_0");
    run(2'b00, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 1, "div_m9_0");
    run(2'b10, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 1, "rem_m9_0");
`ifdef DIV_EARLY_OUT_EN
    run(2'b01, 32'd3, 32'd10, 32'd0, 1, "divu_3_10");
    run(2'b10, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, 1, "rem_m3_10");
`else
    run(2'b01, 32'd3, 32'd10, 32'd0, 33, "divu_3_10");
    run(2'b10, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, 33, "rem_m3_10");
`endif
    run(2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, "div_100_m7");

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      if (i == 7) rb = 32'd0;
      run(ro, ra, rb, model(ro, ra, rb), lat_of(ro, ra, rb), "rand");
    end

    // Flush mid-operation, then restart on the following cycle.
    launch(2'b01, 32'd1000, 32'd3, 32'd0, 0, 1'b0, "annul_op");
    repeat (9) tick();
    annul = 1'b1;
    #1 check({31'd0, stallreq}, 32'd1, "annul_busy_stall");
    tick();
    annul = 1'b0;
    #1;
    check({31'd0, stallreq}, 32'd0, "annul_idle_stall");
    check({31'd0, valid}, 32'd0, "annul_no_valid");
    run(2'b01, 32'd1000, 32'd3, 32'd333, 33, "after_annul");

    // Extra start while busy must not disturb the latched operation.
    launch(2'b01, 32'd1000, 32'd3, 32'd333, 33, 1'b1, "busy_start");
    repeat (2) tick();
    start = 1'b1; op = 2'b11; s1data = 32'd7; s2data = 32'd2;
    tick();
    start = 1'b0;
    collect();

    // Reset in the middle of BUSY aborts with no valid.
    launch(2'b01, 32'd1000, 32'd3, 32'd0, 0, 1'b0, "rst_op");
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check({31'd0, stallreq}, 32'd0, "rst_abort_stall");
    check({31'd0, valid}, 32'd0, "rst_abort_valid");
    check(result, 32'd0, "rst_abort_result");
    saw_valid = 1'b0;
    repeat (40) begin
      tick();
      if (valid === 1'b1) saw_valid = 1'b1;
    end
    check({31'd0, saw_valid}, 32'd0, "rst_no_late_valid");

    // annul beats start in IDLE.
    start = 1'b1; annul = 1'b1; op = 2'b01; s1data = 32'd50; s2data = 32'd5;
    #1 check({31'd0, stallreq}, 32'd0, "annul_start_stall");
    tick();
    start = 1'b0; annul = 1'b0;
    #1;
    check({31'd0, stallreq}, 32'd0, "annul_start_stays_idle");
    check({31'd0, valid}, 32'd0, "annul_start_no_valid");
    tick();
    run(2'b11, 32'd50, 32'd7, 32'd1, 33, "remu_50_7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_div_ctrl.md
EX_DIV_CTRL -- requirements
Module: ex_div_ctrl

Interface
REQ-001 The block SHALL have one clock and use synchronous, active-high reset; ports SHALL be listed clock and reset first.
REQ-002 The block SHALL provide port `clk`: input, 1 bit, rising-edge clock.
REQ-003 The block SHALL provide port `rst`: input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL provide port `start`: input, 1 bit, EX stage requests a divide this cycle.
REQ-005 The block SHALL provide port `op`: input, 2 bits, operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 The block SHALL provide port `s1data`: input, 32 bits, dividend (already forwarded).
REQ-007 The block SHALL provide port `s2data`: input, 32 bits, divisor (already forwarded).
REQ-008 The block SHALL provide port `annul`: input, 1 bit, pipeline flush that cancels any operation in flight.
REQ-009 The block SHALL provide port `stallreq`: output, 1 bit, freezes the pipeline while a divide is pending.
REQ-010 The block SHALL provide port `valid`: output, 1 bit, one-cycle pulse marking `result` as valid.
REQ-011 The block SHALL provide port `result`: output, 32 bits, quotient or remainder, selected by the latched `op`.

Function
REQ-012 States SHALL be IDLE, BUSY and DONE.
REQ-013 In IDLE, `start`=1 with `annul`=0 SHALL latch `op`, |s1data|, |s2data| and the result sign flags.
  - Signed ops (DIV, REM): magnitudes are taken from two's complement.
REQ-014 IDLE transitions on `start`=1:
  - to DONE if the divisor is 0;
  - otherwise to BUSY with the iteration counter at 0.
REQ-015 BUSY SHALL run one restoring shift-subtract step per cycle on a 33-bit partial remainder.
  - It SHALL go to DONE after exactly 32 steps (counter 0..31, 5-bit; terminal count 31).
REQ-016 In DONE, `valid`=1 for exactly one cycle and `result` SHALL hold the signed-corrected value; the next state SHALL be IDLE.
REQ-017 `stallreq` SHALL be combinational:
  - 1 when (IDLE and `start` and not `annul`) or in BUSY;
  - 0 in DONE and otherwise.
REQ-018 Latency without early-out SHALL be: `start` at cycle T, `valid` at T+33. With divisor 0, `valid` SHALL come at T+1.
REQ-019 Divide by zero SHALL give:
  - DIV/DIVU: quotient 0xFFFFFFFF;
  - REM/REMU: remainder equal to the original `s1data`.
REQ-020 Signed results:
  - the quotient is negated if the operand signs differ;
  - the remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF SHALL give 0x80000000; the matching REM SHALL give 0.
REQ-021 `start` in BUSY or DONE SHALL be ignored. Latched operands SHALL NOT change until IDLE.
REQ-022 `annul`=1 in any state SHALL force IDLE next cycle.
  - `valid` SHALL NOT pulse for the cancelled operation.
  - `annul` together with `start` in IDLE SHALL win: no latch, `stallreq`=0.
REQ-023 `result` SHALL hold its last value outside DONE; consumers SHALL qualify it with `valid` only.

Reset
REQ-024 `rst`=1 at a clock edge SHALL force IDLE, counter 0, `valid` 0, `result` 0x00000000 and all operand registers 0.
REQ-025 `rst` during BUSY SHALL abort the operation with no `valid` pulse. `stallreq` SHALL be 0 the cycle after reset unless `start` is asserted.
REQ-026 `rst` SHALL take priority over `annul` and `start`.

Configuration
REQ-027 Macro `DIV_EARLY_OUT_EN`, when defined, SHALL make IDLE go straight to DONE if |dividend| < |divisor| (unsigned magnitude compare).
  - Result: quotient 0, remainder = original `s1data`; `valid` at T+1.
REQ-028 When `DIV_EARLY_OUT_EN` is undefined, such operands SHALL take the full 32-step path, with identical numeric results at T+33.

Verification
REQ-029 DIVU 100/7, `start` at T: `stallreq`=1 for T..T+32, `valid`=1 at T+33, `result`=14; repeat with REMU: `result`=2.
REQ-030 DIV 0xFFFFFFF9 (-7) / 2: `result` 0xFFFFFFFD (-3); REM with the same operands: `result` 0xFFFFFFFF (-1).
REQ-031 DIV 0x80000000 / 0xFFFFFFFF: `result` 0x80000000; REMU 5/0: `valid` at T+1, `result` 5; DIVU 5/0: `result` 0xFFFFFFFF.
REQ-032 DIVU 1000/3, `annul` at T+10: IDLE at T+11, `stallreq` 0, no `valid` pulse. A new `start` at T+11 SHALL then complete normally at T+44.
REQ-033 DIVU 3/10:
  - with `DIV_EARLY_OUT_EN` defined: `valid` at T+1, `result` 0;
  - with it undefined: `valid` at T+33, `result` 0.
REQ-034 `rst` pulsed at T+5 of a BUSY operation: IDLE, `result` 0, no `valid`. Extra `start` pulses during BUSY SHALL leave the latched operands and result unchanged.
